// File: rtl/chain_dp_update_if.sv
// Handshake bundle for chain_dp_update: anchor start, candidate stream and result port.
// The slave modport is the DP update block; the master modport is its driver/consumer.
interface chain_dp_update_if;
    logic        start;
    logic        start_ready;
    logic        start_empty;
    logic [15:0] anchor_idx;
    logic [31:0] anchor_w;

    logic        cand_valid;
    logic        cand_ready;
    logic [15:0] cand_idx;
    logic [31:0] cand_f;
    logic [31:0] cand_score;
    logic        cand_drop;
    logic        cand_last;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_idx;
    logic [31:0] out_f;
    logic [15:0] out_p;

    logic        busy;

    modport slave (
        input  start, start_empty, anchor_idx, anchor_w,
        input  cand_valid, cand_idx, cand_f, cand_score, cand_drop, cand_last,
        input  out_ready,
        output start_ready, cand_ready, out_valid, out_idx, out_f, out_p, busy
    );

    modport master (
        output start, start_empty, anchor_idx, anchor_w,
        output cand_valid, cand_idx, cand_f, cand_score, cand_drop, cand_last,
        output out_ready,
        input  start_ready, cand_ready, out_valid, out_idx, out_f, out_p, busy
    );
endinterface

// File: rtl/chain_dp_update.sv
// Chaining DP update: f[i] = max(anchor_w, max_j sat(f[j] + score_ij)) with predecessor p[i].
// Optional macro CHAIN_BEST_TRACK_EN adds best_f/best_idx tracking across finished anchors.
module chain_dp_update (
    input  logic                clk,
    input  logic                reset,
    chain_dp_update_if.slave    dp
`ifdef CHAIN_BEST_TRACK_EN
    ,
    output logic signed [31:0]  best_f,
    output logic        [15:0]  best_idx
`endif
);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

    state_e state_q, state_d;
    logic   drain_cnt_q, drain_cnt_d;

    logic start_ready, cand_ready, out_valid, busy;
    logic start_xfer, cand_xfer, out_xfer;

    logic        [32:0] sum_full;
    logic        [31:0] sum_sat;
    logic               s1_valid_q;
    logic        [31:0] s1_sum_q;
    logic        [15:0] s1_idx_q;

    logic signed [31:0] f_best_q;
    logic        [15:0] p_best_q;
    logic        [15:0] anchor_idx_q;

    assign start_xfer = dp.start && start_ready;
    assign cand_xfer  = dp.cand_valid && cand_ready;
    assign out_xfer   = out_valid && dp.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        start_ready = 1'b0;
        cand_ready  = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (dp.start) begin
                    state_d = dp.start_empty ? StOut : StAccum;
                end
            end
            StAccum: begin
                cand_ready = 1'b1;
                if (dp.cand_valid && dp.cand_last) begin
                    state_d     = StDrain;
                    drain_cnt_d = 1'b0;
                end
            end
            StDrain: begin
                // Two cycles let the last candidate clear both pipeline stages.
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (dp.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Signed 33-bit sum, clamped back into the 32-bit signed range.
    always_comb begin
        sum_full = {dp.cand_f[31], dp.cand_f} + {dp.cand_score[31], dp.cand_score};
        if (sum_full[32] != sum_full[31]) begin
            sum_sat = sum_full[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sum_sat = sum_full[31:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= 32'h0;
            s1_idx_q     <= 16'h0;
            f_best_q     <= 32'sh0;
            p_best_q     <= 16'hFFFF;
            anchor_idx_q <= 16'h0;
        end else begin
            s1_valid_q <= cand_xfer && !dp.cand_drop;
            if (cand_xfer) begin
                s1_sum_q <= sum_sat;
                s1_idx_q <= dp.cand_idx;
            end
            if (start_xfer) begin
                f_best_q     <= $signed(dp.anchor_w);
                p_best_q     <= 16'hFFFF;
                anchor_idx_q <= dp.anchor_idx;
            end else if (s1_valid_q && ($signed(s1_sum_q) > f_best_q)) begin
                // Strict compare: on a tie the earlier candidate wins.
                f_best_q <= $signed(s1_sum_q);
                p_best_q <= s1_idx_q;
            end
        end
    end

`ifdef CHAIN_BEST_TRACK_EN
    logic signed [31:0] best_f_q;
    logic        [15:0] best_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_f_q   <= 32'sh8000_0000;
            best_idx_q <= 16'h0;
        end else if (out_xfer && (f_best_q > best_f_q)) begin
            best_f_q   <= f_best_q;
            best_idx_q <= anchor_idx_q;
        end
    end

    assign best_f   = best_f_q;
    assign best_idx = best_idx_q;
`else
    // Default build: no cross-anchor best tracking.
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

    assign dp.start_ready = start_ready;
    assign dp.cand_ready  = cand_ready;
    assign dp.out_valid   = out_valid;
    assign dp.busy        = busy;
    assign dp.out_idx     = anchor_idx_q;
    assign dp.out_f       = f_best_q;
    assign dp.out_p       = p_best_q;

endmodule

// File: tb/tb_chain_dp_update.sv
// Scoreboard bench for chain_dp_update: stimulus pushes expected results, a monitor pops them.
// Define CHAIN_BEST_TRACK_EN to also check best_f/best_idx.
module tb_chain_dp_update;

    logic clk = 1'b0;
    logic reset;

    chain_dp_update_if bus ();

`ifdef CHAIN_BEST_TRACK_EN
    logic signed [31:0] best_f;
    logic        [15:0] best_idx;
`endif

    chain_dp_update dut (
        .clk      (clk),
        .reset    (reset),
        .dp       (bus.slave)
`ifdef CHAIN_BEST_TRACK_EN
        ,
        .best_f   (best_f),
        .best_idx (best_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] f;
        logic [15:0] p;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

`ifdef CHAIN_BEST_TRACK_EN
    logic signed [31:0] model_best_f   = 32'sh8000_0000;
    logic        [15:0] model_best_idx = 16'h0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {16'h0, bus.out_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_idx", {16'h0, bus.out_idx}, {16'h0, e.idx});
                check("out_f", bus.out_f, e.f);
                check("out_p", {16'h0, bus.out_p}, {16'h0, e.p});
`ifdef CHAIN_BEST_TRACK_EN
                if ($signed(e.f) > model_best_f) begin
                    model_best_f   = $signed(e.f);
                    model_best_idx = e.idx;
                end
`endif
            end
        end
    end

    task automatic do_start(input logic [15:0] idx, input logic [31:0] w, input logic empty);
        int n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("start_ready_wait", {31'h0, bus.start_ready}, 32'h1);
        bus.start       = 1'b1;
        bus.anchor_idx  = idx;
        bus.anchor_w    = w;
        bus.start_empty = empty;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_cand(input logic [15:0] j, input logic [31:0] f, input logic [31:0] s,
                             input logic drop, input logic last);
        int n = 0;
        bus.cand_valid = 1'b1;
        bus.cand_idx   = j;
        bus.cand_f     = f;
        bus.cand_score = s;
        bus.cand_drop  = drop;
        bus.cand_last  = last;
        while (!bus.cand_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cand_ready_wait", {31'h0, bus.cand_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.cand_valid = 1'b0;
        bus.cand_last  = 1'b0;
    endtask

    // Called right after the cand_last transfer: out_valid must rise exactly two cycles later.
    task automatic check_latency();
        @(negedge clk);
        check("lat_cycle0", {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check("lat_cycle1", {31'h0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check("lat_cycle2", {31'h0, bus.out_valid}, 32'h1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", {31'h0, bus.start_ready}, 32'h1);
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.start_empty = 1'b0;
        bus.anchor_idx  = 16'h0;
        bus.anchor_w    = 32'h0;
        bus.cand_valid  = 1'b0;
        bus.cand_idx    = 16'h0;
        bus.cand_f      = 32'h0;
        bus.cand_score  = 32'h0;
        bus.cand_drop   = 1'b0;
        bus.cand_last   = 1'b0;
        bus.out_ready   = 1'b1;

        @(negedge clk);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_start_ready", {31'h0, bus.start_ready}, 32'h1);
        check("rst_cand_ready", {31'h0, bus.cand_ready}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_out_idx", {16'h0, bus.out_idx}, 32'h0);
        check("rst_out_f", bus.out_f, 32'h0);
        check("rst_out_p", {16'h0, bus.out_p}, 32'h0000_FFFF);
`ifdef CHAIN_BEST_TRACK_EN
        check("rst_best_f", best_f, 32'h8000_0000);
        check("rst_best_idx", {16'h0, best_idx}, 32'h0);
`endif
        @(posedge clk);
        #1;

        // Basic chain: 15 -> 50 (j1) -> 48 rejected -> 55 (j3).
        exp_q.push_back('{idx: 16'd5, f: 32'd55, p: 16'd3});
        do_start(16'd5, 32'd15, 1'b0);
        send_cand(16'd1, 32'd40, 32'd10, 1'b0, 1'b0);
        send_cand(16'd2, 32'd60, -32'sd12, 1'b0, 1'b0);
        send_cand(16'd3, 32'd30, 32'd25, 1'b0, 1'b1);
        check_latency();
        wait_idle();

        // Tie keeps the earlier candidate.
        exp_q.push_back('{idx: 16'd9, f: 32'd25, p: 16'd7});
        do_start(16'd9, 32'd3, 1'b0);
        send_cand(16'd7, 32'd20, 32'd5, 1'b0, 1'b0);
        send_cand(16'd8, 32'd10, 32'd15, 1'b0, 1'b1);
        check_latency();
        wait_idle();

        // Empty anchor: result on the next cycle.
        exp_q.push_back('{idx: 16'd11, f: 32'd19, p: 16'hFFFF});
        do_start(16'd11, 32'd19, 1'b1);
        @(negedge clk);
        check("empty_next_cycle", {31'h0, bus.out_valid}, 32'h1);
        wait_idle();

        // All candidates dropped.
        exp_q.push_back('{idx: 16'd12, f: 32'd19, p: 16'hFFFF});
        do_start(16'd12, 32'd19, 1'b0);
        send_cand(16'd1, 32'd100, 32'd0, 1'b1, 1'b0);
        send_cand(16'd2, 32'd200, 32'd0, 1'b1, 1'b1);
        check_latency();
        wait_idle();

        // Positive saturation with a 10-cycle output stall.
        bus.out_ready = 1'b0;
        exp_q.push_back('{idx: 16'd13, f: 32'h7FFF_FFFF, p: 16'd4});
        do_start(16'd13, 32'd7, 1'b0);
        send_cand(16'd4, 32'h7FFF_FFF0, 32'h100, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.start      = 1'b1;
        bus.start_empty = 1'b1;
        bus.cand_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, bus.out_valid}, 32'h1);
            check("stall_idx", {16'h0, bus.out_idx}, 32'd13);
            check("stall_f", bus.out_f, 32'h7FFF_FFFF);
            check("stall_p", {16'h0, bus.out_p}, 32'd4);
            check("stall_cand_ready", {31'h0, bus.cand_ready}, 32'h0);
            check("stall_start_ready", {31'h0, bus.start_ready}, 32'h0);
        end
        bus.start       = 1'b0;
        bus.start_empty = 1'b0;
        bus.cand_valid  = 1'b0;
        bus.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        wait_idle();

        // Reset mid-anchor: no output, then a fresh anchor runs cleanly.
        do_start(16'd20, 32'd1, 1'b0);
        send_cand(16'd1, 32'd3, 32'd3, 1'b0, 1'b0);
        send_cand(16'd2, 32'd4, 32'd4, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_start_ready", {31'h0, bus.start_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_out", {31'h0, bus.out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back('{idx: 16'd21, f: 32'd10, p: 16'd1});
        do_start(16'd21, 32'd2, 1'b0);
        send_cand(16'd1, 32'd5, 32'd5, 1'b0, 1'b1);
        check_latency();
        wait_idle();

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'h0);

`ifdef CHAIN_BEST_TRACK_EN
        @(negedge clk);
        check("best_f", best_f, model_best_f);
        check("best_idx", {16'h0, best_idx}, {16'h0, model_best_idx});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
